// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, one-outstanding imem request, IF/ID register, halt detect.
// Optional build macro FETCH_ZERO_ON_FLUSH_EN: flush also zeroes IF/ID data fields and the hold buffer.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] pc_cur,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        halted
);

  // state | meaning
  // IDLE  | post-reset bubble, no request
  // REQ   | request outstanding at pc_cur
  // HOLD  | fetched word parked while IF/ID is stalled full
  // HALT  | halt opcode fetched, fetch frozen until flush
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q;
  logic [15:0] pc_redirect;
  logic [15:0] pc_plus2;
  logic        ifid_valid_q;
  logic [15:0] ifid_instr_q;
  logic [15:0] ifid_pc_plus2_q;
  logic [15:0] hold_instr_q;
  logic [15:0] hold_pc_plus2_q;
  logic        halted_q;

  logic        ack_taken;
  logic        ifid_accept;
  logic        req_load;
  logic        req_park;
  logic        hold_load;
  logic        ifid_load;
  logic        halt_seen;
  logic        pc_update;
  logic [15:0] load_instr;
  logic [15:0] load_pc_plus2;

  // Instruction addresses are halfword aligned.
  assign pc_redirect   = pc_next & 16'hFFFE;
  assign pc_plus2      = pc_q + 16'd2;

  assign ack_taken     = (state_q == REQ) && imem_ack;
  assign ifid_accept   = !ifid_valid_q || !stall;
  assign req_load      = ack_taken && !flush && ifid_accept;
  assign req_park      = ack_taken && !flush && !ifid_accept;
  assign hold_load     = (state_q == HOLD) && !flush && !stall;
  assign ifid_load     = req_load || hold_load;
  assign load_instr    = hold_load ? hold_instr_q : imem_data;
  assign load_pc_plus2 = hold_load ? hold_pc_plus2_q : pc_plus2;
  assign halt_seen     = (req_load || req_park) && (imem_data[15:12] == 4'hF);
  assign pc_update     = ack_taken || (flush && ((state_q == HOLD) || (state_q == HALT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack && !flush) begin
          if (ifid_accept) begin
            state_d = (imem_data[15:12] == 4'hF) ? HALT : REQ;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = REQ;
        end else if (!stall) begin
          state_d = (hold_instr_q[15:12] == 4'hF) ? HALT : REQ;
        end
      end
      HALT: begin
        if (flush) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if (state_q == REQ) begin
      imem_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 16'h0000;
    end else if (pc_update) begin
      pc_q <= pc_redirect;
    end
  end

  // Flush beats stall; a load into an empty IF/ID proceeds even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= 16'h0000;
      ifid_pc_plus2_q <= 16'h0000;
    end else if (flush) begin
      ifid_valid_q    <= 1'b0;
`ifdef FETCH_ZERO_ON_FLUSH_EN
      ifid_instr_q    <= 16'h0000;
      ifid_pc_plus2_q <= 16'h0000;
`endif
    end else if (ifid_load) begin
      ifid_valid_q    <= 1'b1;
      ifid_instr_q    <= load_instr;
      ifid_pc_plus2_q <= load_pc_plus2;
    end else if (!stall) begin
      ifid_valid_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr_q    <= 16'h0000;
      hold_pc_plus2_q <= 16'h0000;
    end else if (req_park) begin
      hold_instr_q    <= imem_data;
      hold_pc_plus2_q <= pc_plus2;
    end
`ifdef FETCH_ZERO_ON_FLUSH_EN
    else if (flush) begin
      hold_instr_q    <= 16'h0000;
      hold_pc_plus2_q <= 16'h0000;
    end
`endif
  end

  // Raised as soon as a halt word is captured, including into the hold buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (flush) begin
      halted_q <= 1'b0;
    end else if (halt_seen) begin
      halted_q <= 1'b1;
    end
  end

  assign imem_addr     = pc_q;
  assign pc_cur        = pc_q;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus2 = ifid_pc_plus2_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized memory latency, stalls and flushes against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_next = 16'h0000;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc_cur;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next       (pc_next),
    .stall         (stall),
    .flush         (flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .pc_cur        (pc_cur),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .halted        (halted)
  );

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Reference model: the fetched-word stream and where each word currently sits.
  logic [31:0] exp_q[$];
  logic [31:0] park_q[$];
  logic [15:0] m_pc, m_ii, m_ip;
  bit          m_iv, m_halted, m_warmup, m_frozen;

  logic [15:0] mem_over [logic [15:0]];
  int wait_cnt = 0;
  int lat = 1;
  int lat_fixed = 1;

  function automatic bit m_req();
    return !m_warmup && !m_frozen && (park_q.size() == 0);
  endfunction

  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [15:0] h;
    if (mem_over.exists(a)) return mem_over[a];
    h = a * 16'h9E37;
    return h ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ii = 16'h0000; m_ip = 16'h0000;
    m_iv = 1'b0; m_halted = 1'b0; m_warmup = 1'b1; m_frozen = 1'b0;
    park_q.delete();
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [15:0] tgt, gi, gp, old_pc;
    logic [31:0] b;
    bit got;
    got = 1'b0;
    gi = 16'h0000;
    gp = 16'h0000;
    tgt = {pc_next[15:1], 1'b0};
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_warmup) begin
      m_warmup = 1'b0;
    end else if (m_frozen) begin
      if (flush) begin
        m_pc = tgt; m_frozen = 1'b0; m_halted = 1'b0;
      end
    end else if (park_q.size() != 0) begin
      if (flush) begin
        park_q.delete(); m_pc = tgt; m_halted = 1'b0;
      end else if (!stall) begin
        b = park_q.pop_front();
        got = 1'b1; gi = b[31:16]; gp = b[15:0];
        m_frozen = (gi[15:12] == 4'hF);
      end
    end else if (imem_ack) begin
      old_pc = m_pc;
      m_pc = tgt;
      if (!flush) begin
        if (!m_iv || !stall) begin
          got = 1'b1; gi = imem_data; gp = old_pc + 16'd2;
          m_frozen = (gi[15:12] == 4'hF);
        end else begin
          park_q.push_back({imem_data, old_pc + 16'd2});
        end
        if (imem_data[15:12] == 4'hF) m_halted = 1'b1;
      end
    end
    if (flush) begin
      m_iv = 1'b0;
`ifdef FETCH_ZERO_ON_FLUSH_EN
      m_ii = 16'h0000;
      m_ip = 16'h0000;
`endif
    end else if (got) begin
      m_iv = 1'b1; m_ii = gi; m_ip = gp;
      exp_q.push_back({gi, gp});
    end else if (!stall) begin
      m_iv = 1'b0;
    end
  endtask

  always @(posedge clk) model_step();

  always @(posedge clk) begin : monitor
    logic pv, ps, pf, pr;
    logic [31:0] e;
    pv = ifid_valid; ps = stall; pf = flush; pr = rst_n;
    #1;
    if (pr && rst_n && !done) begin
      chk1("imem_req", imem_req, m_req());
      chk("pc_cur", pc_cur, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk1("halted", halted, m_halted);
      chk1("ifid_valid", ifid_valid, m_iv);
      chk("ifid_instr", ifid_instr, m_ii);
      chk("ifid_pc_plus2", ifid_pc_plus2, m_ip);
      if (ifid_valid && !(pv && ps && !pf)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got instr %h pc+2 %h, expected no delivery at %0t",
                   ifid_instr, ifid_pc_plus2, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", ifid_instr, e[31:16]);
          chk("sb_pc_plus2", ifid_pc_plus2, e[15:0]);
        end
      end
    end
  end

  // flmode: 0 none, 1 always, 2 only with an ack, 3 random where the redirect is defined
  task automatic cycle(input bit st, input int flmode, input logic [15:0] tgt, input bit odd);
    @(negedge clk);
    stall = st;
    if (imem_req) begin
      if (wait_cnt >= lat) begin
        imem_ack = 1'b1;
        wait_cnt = 0;
        lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
    imem_data = imem_ack ? word_at(imem_addr) : 16'($urandom);
    case (flmode)
      1: flush = 1'b1;
      2: flush = imem_ack;
      3: flush = (imem_ack || (park_q.size() != 0) || m_frozen) && ($urandom_range(0, 9) == 0);
      default: flush = 1'b0;
    endcase
    pc_next = flush ? tgt : ((m_pc + 16'd2) | {15'd0, odd});
    @(posedge clk);
    #2;
  endtask

  task automatic bound_chk(input string nm, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: event not seen within cycle budget, required it to occur", nm);
    end
  endtask

  initial begin
    model_reset();
    mem_over[16'h0000] = 16'h1234;
    mem_over[16'h0002] = 16'h5678;
    mem_over[16'h0040] = 16'hF000;
    mem_over[16'hFFFE] = 16'hA5C3;

    repeat (2) @(negedge clk);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk("rst_pc_cur", pc_cur, 16'h0000);
    chk1("rst_ifid_valid", ifid_valid, 1'b0);
    chk("rst_ifid_instr", ifid_instr, 16'h0000);
    chk("rst_ifid_pc_plus2", ifid_pc_plus2, 16'h0000);
    chk1("rst_halted", halted, 1'b0);
    rst_n = 1'b1;

    // Back-to-back fetch with 1-cycle memory, then a 3-cycle stall over an ack.
    repeat (4) cycle(1'b0, 0, 16'h0000, 1'b0);
    cycle(1'b1, 0, 16'h0000, 1'b0);
    cycle(1'b1, 0, 16'h0000, 1'b0);
    chk1("hold_imem_req", imem_req, 1'b0);
    cycle(1'b1, 0, 16'h0000, 1'b0);
    repeat (4) cycle(1'b0, 0, 16'h0000, 1'b0);

    // Flush coincident with an ack, redirect onto a halt word.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 2, 16'h0040, 1'b0);
      if (flush) break;
    end
    bound_chk("flush_ack_0040", flush);
    chk1("flush_ifid_valid", ifid_valid, 1'b0);
    chk1("flush_imem_req", imem_req, 1'b1);
    chk("flush_imem_addr", imem_addr, 16'h0040);

    for (int i = 0; i < 10; i++) begin
      if (halted) break;
      cycle(1'b0, 0, 16'h0000, 1'b0);
    end
    bound_chk("halt_reached", halted);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 0, 16'h0000, 1'b0);
      chk1("halt_imem_req", imem_req, 1'b0);
    end
    chk1("halt_still_halted", halted, 1'b1);
    cycle(1'b0, 1, 16'h0010, 1'b0);
    chk1("unhalt_halted", halted, 1'b0);
    chk1("unhalt_imem_req", imem_req, 1'b1);
    chk("unhalt_imem_addr", imem_addr, 16'h0010);

    // PC+2 wrap at the top of the address space.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 2, 16'hFFFE, 1'b0);
      if (flush) break;
    end
    bound_chk("flush_ack_fffe", flush);
    chk("wrap_pc_cur", pc_cur, 16'hFFFE);
    cycle(1'b0, 0, 16'h0000, 1'b0);
    cycle(1'b0, 0, 16'h0000, 1'b0);
    chk1("wrap_ifid_valid", ifid_valid, 1'b1);
    chk("wrap_ifid_instr", ifid_instr, 16'hA5C3);
    chk("wrap_ifid_pc_plus2", ifid_pc_plus2, 16'h0000);

    // IF/ID data after a flush depends on the build option.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 2, 16'h0100, 1'b0);
      if (flush) break;
    end
    bound_chk("flush_ack_0100", flush);
    chk1("zf_ifid_valid", ifid_valid, 1'b0);
`ifdef FETCH_ZERO_ON_FLUSH_EN
    chk("zf_ifid_instr", ifid_instr, 16'h0000);
`else
    chk("zf_ifid_instr", ifid_instr, 16'hA5C3);
`endif

    // Asynchronous reset with a request outstanding, then a stale ack.
    lat_fixed = 3;
    lat = 3;
    cycle(1'b0, 0, 16'h0000, 1'b0);
    chk1("pre_rst_imem_req", imem_req, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    #2;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    wait_cnt = 0;
    model_reset();
    #1;
    chk1("arst_imem_req", imem_req, 1'b0);
    chk("arst_pc_cur", pc_cur, 16'h0000);
    chk1("arst_ifid_valid", ifid_valid, 1'b0);
    chk("arst_ifid_instr", ifid_instr, 16'h0000);
    chk("arst_ifid_pc_plus2", ifid_pc_plus2, 16'h0000);
    chk1("arst_halted", halted, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_data = 16'h7777;
    pc_next = 16'h0200;
    @(posedge clk);
    #2;
    imem_ack = 1'b0;
    chk1("stale_ack_ifid_valid", ifid_valid, 1'b0);
    chk("stale_ack_pc_cur", pc_cur, 16'h0000);

    // Randomized traffic.
    lat_fixed = 0;
    for (int i = 0; i < 1500; i++) begin
      bit st;
      st = ($urandom_range(0, 9) < 3);
      cycle(st, 3, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    cycle(1'b0, 0, 16'h0000, 1'b0);

    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d undelivered words, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
